mc14500b_program_loader: RTL



---
 rtl/mc14500b_program_loader_pkg.sv | 20 ++
 rtl/mc14500b_program_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc14500b_program_loader_pkg.sv
// Shared widths and the loader state type for the MC14500B program loader.
package mc14500b_program_loader_pkg;

    localparam int OPCODE_W = 4;
    localparam int ADDR_W   = 8;
    localparam int CMD_W    = OPCODE_W + ADDR_W;

    typedef enum logic [3:0] {
        IDLE,
        PRE_RST,
        GET_HI,
        GET_LO,
        WRITE,
        GAP,
        GET_CSUM,
        POST_RST,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/mc14500b_program_loader.sv
// Framed byte-stream loader: packs {hi,lo} pairs into core commands and
// sequences the core reset around a checksummed program image.
//
// state    | meaning
// IDLE     | waiting for header byte N
// PRE_RST  | core_rst pulse before loading
// GET_HI   | waiting for opcode byte
// GET_LO   | waiting for address byte
// WRITE    | program_write strobe
// GAP      | enforced low time between writes
// GET_CSUM | waiting for checksum byte
// POST_RST | core_rst release pulse after a good image
// DRAIN    | discarding the rest of a bad frame
module mc14500b_program_loader
    import mc14500b_program_loader_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int WRITE_GAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             program_write,
    output logic [CMD_W-1:0] program_cmd,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD = 4'(WRITE_GAP - 1);

    loader_state_e         state_q, state_d;
    logic [7:0]            n_q, n_d;
    logic [7:0]            csum_q, csum_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic [3:0]            timer_q, timer_d;
    logic [8:0]            drain_q, drain_d;
    logic                  core_rst_q, core_rst_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  accept;

    // in_ready is gated by rst so nothing is offered as accepted while held in reset
    assign in_ready = rst && (state_q inside {IDLE, GET_HI, GET_LO, GET_CSUM, DRAIN});
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            csum_q     <= '0;
            opcode_q   <= '0;
            cmd_q      <= '0;
            timer_q    <= '0;
            drain_q    <= '0;
            core_rst_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            csum_q     <= csum_d;
            opcode_q   <= opcode_d;
            cmd_q      <= cmd_d;
            timer_q    <= timer_d;
            drain_q    <= drain_d;
            core_rst_q <= core_rst_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        csum_d     = csum_q;
        opcode_d   = opcode_q;
        cmd_d      = cmd_q;
        timer_d    = timer_q;
        drain_d    = drain_q;
        core_rst_d = core_rst_q;
        err_d      = err_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    n_d        = in_data;
                    csum_d     = in_data;
                    err_d      = 1'b0;
                    core_rst_d = 1'b1;
                    timer_d    = RST_LOAD;
                    state_d    = PRE_RST;
                end
            end
            PRE_RST: begin
                if (timer_q == 4'd0) begin
                    core_rst_d = 1'b0;
                    state_d    = (n_q == 8'd0) ? GET_CSUM : GET_HI;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            GET_HI: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (in_data[7:4] != 4'd0) begin
                        err_d   = 1'b1;
                        // lo byte of this pair, the remaining pairs, and the checksum
                        drain_d = {n_q, 1'b0};
                        state_d = DRAIN;
                    end else begin
                        opcode_d = in_data[OPCODE_W-1:0];
                        state_d  = GET_LO;
                    end
                end
            end
            GET_LO: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    cmd_d   = {opcode_q, in_data};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                n_d     = n_q - 8'd1;
                timer_d = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (timer_q == 4'd0) begin
                    state_d = (n_q != 8'd0) ? GET_HI : GET_CSUM;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            GET_CSUM: begin
                if (accept) begin
                    core_rst_d = 1'b1;
                    if (in_data == csum_q) begin
                        timer_d = RST_LOAD;
                        state_d = POST_RST;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            POST_RST: begin
                if (timer_q == 4'd0) begin
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (drain_q == 9'd1) begin
                        core_rst_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        drain_d = drain_q - 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign program_write = (state_q == WRITE);
    assign program_cmd   = cmd_q;
    assign core_rst      = core_rst_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule
